// File: rtl/shift_reg_sequencer.sv
// Purpose: sequences an external 4-bit universal shift register to serialize one word (load, then N_SHIFT shifts).
// Latency: accept at edge k -> LOAD k+1, SHIFT k+2..k+1+N_SHIFT, done pulse k+2+N_SHIFT, ready again the next cycle.
// Backpressure: start_ready is high only in IDLE; start_valid is ignored while a word is in flight.
// Build option: define SHIFT_REG_SEQ_ROTATE_EN to feed the shifted-out bit back in (rotate) instead of zero-fill.
module shift_reg_sequencer #(
  parameter int N_SHIFT = 4  // shift cycles per word, legal 1..4
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       dir,
  input  logic [3:0] data_in,
  input  logic [3:0] A_par,
  output logic       s1,
  output logic       s0,
  output logic [3:0] I_par,
  output logic       MSB_in,
  output logic       LSB_in,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter runs 0..N_SHIFT-1 during SHIFT; two bits cover the legal range.
  localparam logic [1:0] LAST_CNT = 2'(N_SHIFT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] shift_cnt;
  logic [3:0] word_q;
  logic       dir_q;
  logic       accept;

  assign accept = start_valid && (state == IDLE);

  // State register; Clear wins over any pending transition, including an accept.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture and shift counter; word and direction are frozen after accept.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      word_q    <= 4'h0;
      dir_q     <= 1'b0;
      shift_cnt <= 2'd0;
    end else if (accept) begin
      word_q    <= data_in;
      dir_q     <= dir;
      shift_cnt <= 2'd0;
    end else if (state == SHIFT) begin
      shift_cnt <= shift_cnt + 2'd1;
    end
  end

  // Next-state: one LOAD cycle, N_SHIFT SHIFT cycles, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the serial bit is taken live from the register's parallel output.
  always_comb begin
    start_ready = 1'b0;
    s1          = 1'b0;
    s0          = 1'b0;
    MSB_in      = 1'b0;
    LSB_in      = 1'b0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: start_ready = 1'b1;
      LOAD: begin
        s1 = 1'b1;
        s0 = 1'b1;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        if (dir_q) begin
          // Shift left: MSB leaves first, fill enters at the LSB.
          s1      = 1'b1;
          ser_out = A_par[3];
`ifdef SHIFT_REG_SEQ_ROTATE_EN
          LSB_in  = A_par[3];
`endif
        end else begin
          // Shift right: LSB leaves first, fill enters at the MSB.
          s0      = 1'b1;
          ser_out = A_par[0];
`ifdef SHIFT_REG_SEQ_ROTATE_EN
          MSB_in  = A_par[0];
`endif
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Load data is presented continuously; the register only takes it when select is 11.
  assign I_par = word_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer driving a behavioural 4-bit universal shift register.
// Two instances: default N_SHIFT = 4, and N_SHIFT = 1 for the single-shift corner.
// Expected serial streams and final register contents are hand-derived per vector.
module tb_shift_reg_sequencer;

  logic CLK;
  logic Clear;

  // N_SHIFT = 4 instance
  logic       start_valid, start_ready, dir;
  logic [3:0] data_in, A_par, I_par;
  logic       s1, s0, MSB_in, LSB_in, ser_out, ser_valid, done;

  // N_SHIFT = 1 instance
  logic       start_valid1, start_ready1, dir1;
  logic [3:0] data_in1, A_par1, I_par1;
  logic       s1_1, s0_1, MSB_in1, LSB_in1, ser_out1, ser_valid1, done1;

  int vectors     = 0;
  int miscompares = 0;

  shift_reg_sequencer #(.N_SHIFT(4)) dut (
    .CLK(CLK), .Clear(Clear), .start_valid(start_valid), .start_ready(start_ready),
    .dir(dir), .data_in(data_in), .A_par(A_par), .s1(s1), .s0(s0), .I_par(I_par),
    .MSB_in(MSB_in), .LSB_in(LSB_in), .ser_out(ser_out), .ser_valid(ser_valid), .done(done)
  );

  shift_reg_sequencer #(.N_SHIFT(1)) dut1 (
    .CLK(CLK), .Clear(Clear), .start_valid(start_valid1), .start_ready(start_ready1),
    .dir(dir1), .data_in(data_in1), .A_par(A_par1), .s1(s1_1), .s0(s0_1), .I_par(I_par1),
    .MSB_in(MSB_in1), .LSB_in(LSB_in1), .ser_out(ser_out1), .ser_valid(ser_valid1), .done(done1)
  );

  // Behavioural universal shift registers (cleared with the bench reset for a known start).
  always @(posedge CLK) begin
    if (Clear) A_par <= 4'h0;
    else case ({s1, s0})
      2'b01:   A_par <= {MSB_in, A_par[3:1]};
      2'b10:   A_par <= {A_par[2:0], LSB_in};
      2'b11:   A_par <= I_par;
      default: A_par <= A_par;
    endcase
  end

  always @(posedge CLK) begin
    if (Clear) A_par1 <= 4'h0;
    else case ({s1_1, s0_1})
      2'b01:   A_par1 <= {MSB_in1, A_par1[3:1]};
      2'b10:   A_par1 <= {A_par1[2:0], LSB_in1};
      2'b11:   A_par1 <= I_par1;
      default: A_par1 <= A_par1;
    endcase
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One full word on the N_SHIFT = 4 instance; exp_bits[i] is the i-th serial bit.
  task automatic run_word(input logic [3:0] d, input logic dr,
                          input logic [3:0] exp_bits, input logic [3:0] exp_end);
    logic [1:0] shift_sel;
    shift_sel = dr ? 2'b10 : 2'b01;
    start_valid = 1'b1; data_in = d; dir = dr;
    chk("req_ready", 8'(start_ready), 8'd1);
    tick;
    // Change inputs after accept: the DUT must not re-sample them.
    start_valid = 1'b0; data_in = ~d; dir = ~dr;
    chk("load_sel", 8'({s1, s0}), 8'd3);
    chk("load_ipar", 8'(I_par), 8'(d));
    chk("load_ser_valid", 8'(ser_valid), 8'd0);
    chk("load_ready", 8'(start_ready), 8'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("shift_sel", 8'({s1, s0}), 8'(shift_sel));
      chk("shift_ser_valid", 8'(ser_valid), 8'd1);
      chk("shift_ser_out", 8'(ser_out), 8'(exp_bits[i]));
      chk("shift_done", 8'(done), 8'd0);
      tick;
    end
    chk("done_pulse", 8'(done), 8'd1);
    chk("done_sel", 8'({s1, s0}), 8'd0);
    chk("done_ser_valid", 8'(ser_valid), 8'd0);
    chk("done_ready", 8'(start_ready), 8'd0);
    tick;
    chk("post_done", 8'(done), 8'd0);
    chk("post_ready", 8'(start_ready), 8'd1);
    chk("reg_end", 8'(A_par), 8'(exp_end));
    chk("ipar_held", 8'(I_par), 8'(d));
  endtask

  initial begin
    int ready_idx[$];
    int done_cnt;
    logic [3:0] end_a, end_3, end_c, end_1;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
    end_a = 4'hA; end_3 = 4'h3; end_c = 4'hC; end_1 = 4'h8;
`else
    end_a = 4'h0; end_3 = 4'h0; end_c = 4'h0; end_1 = 4'h0;
`endif
    Clear = 1'b1;
    start_valid = 1'b0; dir = 1'b0; data_in = 4'h0;
    start_valid1 = 1'b0; dir1 = 1'b0; data_in1 = 4'h0;
    tick; tick;
    Clear = 1'b0;

    // Reset state
    chk("rst_ready", 8'(start_ready), 8'd1);
    chk("rst_sel", 8'({s1, s0}), 8'd0);
    chk("rst_ipar", 8'(I_par), 8'd0);
    chk("rst_fill", 8'({MSB_in, LSB_in}), 8'd0);
    chk("rst_ser_valid", 8'(ser_valid), 8'd0);
    chk("rst_ser_out", 8'(ser_out), 8'd0);
    chk("rst_done", 8'(done), 8'd0);

    // 4'hA right: 0,1,0,1 ; 4'h3 left: 0,0,1,1
    run_word(4'hA, 1'b0, 4'b1010, end_a);
    run_word(4'h3, 1'b1, 4'b1100, end_3);

    // Held start_valid: accepts once per N_SHIFT + 3 = 7 cycles.
    start_valid = 1'b1; data_in = 4'h5; dir = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (start_ready) ready_idx.push_back(i);
      tick;
    end
    start_valid = 1'b0;
    chk("held_accepts", 8'(ready_idx.size()), 8'd3);
    if (ready_idx.size() == 3) begin
      chk("held_first", 8'(ready_idx[0]), 8'd0);
      chk("held_gap0", 8'(ready_idx[1] - ready_idx[0]), 8'd7);
      chk("held_gap1", 8'(ready_idx[2] - ready_idx[1]), 8'd7);
    end
    chk("held_end_ready", 8'(start_ready), 8'd1);

    // Clear beats a simultaneous accept.
    start_valid = 1'b1; data_in = 4'h6; Clear = 1'b1;
    tick;
    start_valid = 1'b0; Clear = 1'b0;
    chk("clr_prio_ready", 8'(start_ready), 8'd1);
    chk("clr_prio_sel", 8'({s1, s0}), 8'd0);

    // Clear in the 2nd SHIFT cycle aborts without a done pulse.
    start_valid = 1'b1; data_in = 4'h9; dir = 1'b0;
    tick;                       // LOAD
    start_valid = 1'b0;
    tick;                       // SHIFT 1
    tick;                       // SHIFT 2
    chk("abort_in_shift", 8'(ser_valid), 8'd1);
    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    chk("abort_ready", 8'(start_ready), 8'd1);
    chk("abort_sel", 8'({s1, s0}), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_ipar", 8'(I_par), 8'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick;
    end
    chk("abort_no_done", 8'(done_cnt), 8'd0);

    // Following request runs normally: 4'hC right -> 0,0,1,1
    run_word(4'hC, 1'b0, 4'b1100, end_c);

    // N_SHIFT = 1: single serial bit, done at k+3.
    start_valid1 = 1'b1; data_in1 = 4'h1; dir1 = 1'b0;
    chk("n1_ready", 8'(start_ready1), 8'd1);
    tick;                       // k+1
    start_valid1 = 1'b0;
    chk("n1_load_sel", 8'({s1_1, s0_1}), 8'd3);
    tick;                       // k+2
    chk("n1_ser_valid", 8'(ser_valid1), 8'd1);
    chk("n1_ser_out", 8'(ser_out1), 8'd1);
    chk("n1_shift_sel", 8'({s1_1, s0_1}), 8'd1);
    tick;                       // k+3
    chk("n1_done", 8'(done1), 8'd1);
    chk("n1_done_ser_valid", 8'(ser_valid1), 8'd0);
    tick;
    chk("n1_post_done", 8'(done1), 8'd0);
    chk("n1_post_ready", 8'(start_ready1), 8'd1);
    chk("n1_reg_end", 8'(A_par1), 8'(end_1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter: N_SHIFT, 4, number of shift cycles per word (legal 1..4).
REQ-002 SHALL have port: CLK  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port: Clear  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start_valid  input  1  request to serialize data_in.
REQ-005 SHALL have port: start_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port: dir  input  1  shift direction, sampled with the request (0 = right, 1 = left).
REQ-007 SHALL have port: data_in  input  4  word to load, sampled with the request.
REQ-008 SHALL have port: A_par  input  4  parallel output of the controlled 4-bit universal shift register.
REQ-009 SHALL have port: s1, s0  output  1 each  mode select to the register (00 hold, 01 shift right, 10 shift left, 11 load).
REQ-010 SHALL have port: I_par  output  4  parallel load data to the register.
REQ-011 SHALL have port: MSB_in, LSB_in  output  1 each  serial fill bits to the register.
REQ-012 SHALL have port: ser_out  output  1  current serial bit.
REQ-013 SHALL have port: ser_valid  output  1  ser_out is valid this cycle.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at word completion.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-016 SHALL drive start_ready = 1 only in IDLE; a request SHALL be accepted at an edge where start_valid and start_ready are both 1.
REQ-017 On accept, SHALL capture data_in and dir, go to LOAD, and clear the shift counter.
REQ-018 In IDLE and DONE, SHALL drive {s1,s0} = 00 (register holds).
REQ-019 In LOAD, SHALL drive {s1,s0} = 11 and I_par = captured word for exactly one cycle, then go to SHIFT.
REQ-020 In SHIFT, SHALL drive {s1,s0} = 01 if dir = 0, else 10.
REQ-021 SHALL stay in SHIFT for exactly N_SHIFT cycles, incrementing the counter each cycle, then go to DONE.
REQ-022 In SHIFT, SHALL drive ser_valid = 1 and ser_out = A_par[0] if dir = 0, else A_par[3] (combinational from A_par).
REQ-023 Outside SHIFT, SHALL drive ser_valid = 0 and ser_out = 0.
REQ-024 In DONE, SHALL drive done = 1 for one cycle, then go to IDLE.
REQ-025 Latency: accept at edge k gives LOAD in cycle k+1, SHIFT in cycles k+2..k+1+N_SHIFT, done in cycle k+2+N_SHIFT, and start_ready = 1 again in the following cycle.
REQ-026 SHALL ignore start_valid while not in IDLE; a held start_valid is accepted on the first IDLE edge (back-to-back words with a gap of exactly one IDLE cycle).
REQ-027 SHALL not re-sample dir or data_in after accept.
REQ-028 SHALL drive I_par = captured word in every state.

Reset
REQ-029 With Clear = 1 at a rising edge, SHALL enter IDLE, clear the counter and captured word, and drive {s1,s0} = 00, I_par = 0, MSB_in = LSB_in = 0, ser_valid = 0, done = 0, start_ready = 1.
REQ-030 Clear in LOAD, SHIFT or DONE SHALL abort the word with no done pulse; {s1,s0} = 00 from the next cycle.
REQ-031 Clear SHALL take priority over a simultaneous accept.

Configuration
REQ-032 Macro SHIFT_REG_SEQ_ROTATE_EN SHALL select the fill behaviour.
REQ-033 When SHIFT_REG_SEQ_ROTATE_EN is defined, in SHIFT SHALL drive MSB_in = A_par[0] (right) or LSB_in = A_par[3] (left), so that with N_SHIFT = 4 the register ends holding the original word.
REQ-034 When SHIFT_REG_SEQ_ROTATE_EN is not defined, MSB_in and LSB_in SHALL be 0 in all states, so the register ends zero-filled after 4 shifts.

Verification
REQ-035 Bench: reset, then request data_in = 4'hA, dir = 0 -> one LOAD cycle with select 11, then ser_out 0,1,0,1 with ser_valid high for 4 cycles, done pulse; register ends 4'hA with rotate, 4'h0 without.
REQ-036 Bench: request data_in = 4'h3, dir = 1 -> ser_out 0,0,1,1, then done pulse; start_ready = 1 one cycle after done.
REQ-037 Bench: start_valid held high continuously -> accepts exactly one word per N_SHIFT + 3 cycles; requests arriving mid-word are ignored.
REQ-038 Bench: Clear asserted in the 2nd SHIFT cycle -> next cycle is IDLE with select 00, no done pulse, and the following request runs normally.
REQ-039 Bench: N_SHIFT = 1, data_in = 4'h1, dir = 0 -> one ser_valid cycle with ser_out = 1, and done in cycle k+3.
